// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_stage_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned REG_AW          = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [REG_AW-1:0] rd;
    logic              mem_to_reg;
    logic              reg_write;
  } mem_wb_t;

endpackage : mem_stage_pkg

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register; a bubble clears the whole entry so WB sees a no-op.
module mem_wb_register
  import mem_stage_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // Reset and bubble take priority over a normal load.
  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : mem_wb_register

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory accesses, stalls the front of the pipeline
// while waiting for the ack, and feeds the MEM/WB register.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   alu_result_mem,
  input  logic [XLEN-1:0]   read_data2_mem,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              MemRead_mem,
  input  logic              MemtoReg_mem,
  input  logic              MemWrite_mem,
  input  logic              RegWrite_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_mem,
  output logic              mem_error,
  output logic [XLEN-1:0]   read_data_wb,
  output logic [XLEN-1:0]   alu_result_wb,
  output logic [REG_AW-1:0] rd_wb,
  output logic              MemtoReg_wb,
  output logic              RegWrite_wb
);

  // The counter value seen during the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rdata_q;

  logic              any_op, illegal_op, misaligned, bad_op;
  logic              start_acc, ack_hit, time_out, err_d;
  logic              wb_load, wb_bubble, stall_c;
  mem_wb_t           wb_d, wb_q;

  assign any_op     = MemRead_mem | MemWrite_mem;
  assign illegal_op = MemRead_mem & MemWrite_mem;
  assign misaligned = |alu_result_mem[1:0];
  assign bad_op     = illegal_op | (any_op & misaligned);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall, and MEM/WB load/bubble decisions.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    ack_hit   = 1'b0;
    time_out  = 1'b0;
    err_d     = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    stall_c   = 1'b0;
    wb_d      = '{alu_result: alu_result_mem,
                  read_data:  '0,
                  rd:         rd_mem,
                  mem_to_reg: MemtoReg_mem,
                  reg_write:  RegWrite_mem};
    case (state_q)
      ST_IDLE: begin
        if (bad_op) begin
          err_d     = 1'b1;
          wb_bubble = 1'b1;
        end else if (any_op) begin
          stall_c   = 1'b1;
          start_acc = 1'b1;
          wb_bubble = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          wb_load = 1'b1;
        end
      end
      ST_WAIT: begin
        wb_bubble = 1'b1;
        if (dmem_ack) begin
          // An ack in the last permitted cycle still completes normally.
          ack_hit = 1'b1;
          stall_c = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: release the pipeline so the faulting access is dropped.
          time_out = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      ST_DONE: begin
        wb_load        = 1'b1;
        wb_d.read_data = rdata_q;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stall_mem = stall_c & ~reset;

  // Memory-port registers, wait counter, captured load data and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      mem_error  <= 1'b0;
    end else begin
      mem_error <= err_d;
      if (start_acc) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MemWrite_mem;
        dmem_addr  <= alu_result_mem;
        dmem_wdata <= read_data2_mem;
        cnt_q      <= '0;
      end else if (ack_hit) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
        rdata_q  <= dmem_we ? '0 : dmem_rdata;
      end else if (time_out) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  mem_wb_register u_mem_wb (
    .clock  (clock),
    .reset  (reset),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign read_data_wb  = wb_q.read_data;
  assign alu_result_wb = wb_q.alu_result;
  assign rd_wb         = wb_q.rd;
  assign MemtoReg_wb   = wb_q.mem_to_reg;
  assign RegWrite_wb   = wb_q.reg_write;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit, built with a 4-cycle timeout.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic [31:0] alu_result_mem, read_data2_mem, dmem_rdata;
  logic [4:0]  rd_mem;
  logic        MemRead_mem, MemtoReg_mem, MemWrite_mem, RegWrite_mem, dmem_ack;
  logic        dmem_req, dmem_we, stall_mem, mem_error, MemtoReg_wb, RegWrite_wb;
  logic [31:0] dmem_addr, dmem_wdata, read_data_wb, alu_result_wb;
  logic [4:0]  rd_wb;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_result_mem (alu_result_mem),
    .read_data2_mem (read_data2_mem),
    .rd_mem         (rd_mem),
    .MemRead_mem    (MemRead_mem),
    .MemtoReg_mem   (MemtoReg_mem),
    .MemWrite_mem   (MemWrite_mem),
    .RegWrite_mem   (RegWrite_mem),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .stall_mem      (stall_mem),
    .mem_error      (mem_error),
    .read_data_wb   (read_data_wb),
    .alu_result_wb  (alu_result_wb),
    .rd_wb          (rd_wb),
    .MemtoReg_wb    (MemtoReg_wb),
    .RegWrite_wb    (RegWrite_wb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    alu_result_mem = '0; read_data2_mem = '0; rd_mem = '0;
    MemRead_mem = 0; MemtoReg_mem = 0; MemWrite_mem = 0; RegWrite_mem = 0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
    clr();
    alu_result_mem = addr; rd_mem = rd;
    MemRead_mem = 1; MemtoReg_mem = 1; RegWrite_mem = 1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    reset = 1;
    tick(); tick();
    chk("rst_req",   32'(dmem_req), 0);
    chk("rst_stall", 32'(stall_mem), 0);
    chk("rst_err",   32'(mem_error), 0);
    chk("rst_wb",    alu_result_wb, 0);
    chk("rst_rw",    32'(RegWrite_wb), 0);
    reset = 0;

    // ALU op
    alu_result_mem = 32'h10; rd_mem = 5; RegWrite_mem = 1;
    #1 chk("alu_stall", 32'(stall_mem), 0);
    tick();
    chk("alu_res", alu_result_wb, 32'h10);
    chk("alu_rd",  32'(rd_wb), 5);
    chk("alu_rw",  32'(RegWrite_wb), 1);
    chk("alu_rdata", read_data_wb, 0);
    chk("alu_stall2", 32'(stall_mem), 0);
    clr(); tick();

    // Load at 0x100, ack in third WAIT cycle
    set_load(32'h100, 7);
    #1 chk("ld_stall_idle", 32'(stall_mem), 1);
    chk("ld_req_idle", 32'(dmem_req), 0);
    tick();
    chk("ld_w1_req",   32'(dmem_req), 1);
    chk("ld_w1_addr",  dmem_addr, 32'h100);
    chk("ld_w1_we",    32'(dmem_we), 0);
    chk("ld_w1_stall", 32'(stall_mem), 1);
    chk("ld_w1_bub",   32'(RegWrite_wb), 0);
    tick();
    chk("ld_w2_req",   32'(dmem_req), 1);
    chk("ld_w2_stall", 32'(stall_mem), 1);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_w3_req", 32'(dmem_req), 1);
    chk("ld_w3_stall", 32'(stall_mem), 1);
    tick();
    dmem_ack = 0; dmem_rdata = 32'h55555555;
    #1 chk("ld_done_req", 32'(dmem_req), 0);
    chk("ld_done_stall", 32'(stall_mem), 0);
    chk("ld_done_bub",   32'(RegWrite_wb), 0);
    tick();
    chk("ld_rdata", read_data_wb, 32'hDEADBEEF);
    chk("ld_m2r",   32'(MemtoReg_wb), 1);
    chk("ld_rw",    32'(RegWrite_wb), 1);
    chk("ld_rd",    32'(rd_wb), 7);
    chk("ld_alu",   alu_result_wb, 32'h100);
    clr();
    #1 chk("ld_idle_stall", 32'(stall_mem), 0);
    tick();

    // Store at 0x200, zero-wait ack
    alu_result_mem = 32'h200; read_data2_mem = 32'h12345678; MemWrite_mem = 1;
    #1 chk("st_stall_idle", 32'(stall_mem), 1);
    tick();
    chk("st_req",   32'(dmem_req), 1);
    chk("st_we",    32'(dmem_we), 1);
    chk("st_addr",  dmem_addr, 32'h200);
    chk("st_wdata", dmem_wdata, 32'h12345678);
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    #1 chk("st_w1_stall", 32'(stall_mem), 1);
    tick();
    dmem_ack = 0;
    chk("st_done_req", 32'(dmem_req), 0);
    chk("st_done_we",  32'(dmem_we), 0);
    chk("st_wdata_hold", dmem_wdata, 32'h12345678);
    tick();
    chk("st_rw",    32'(RegWrite_wb), 0);
    chk("st_rdata", read_data_wb, 0);
    chk("st_alu",   alu_result_wb, 32'h200);
    clr(); tick();

    // Misaligned load
    set_load(32'h102, 9);
    #1 chk("mis_stall", 32'(stall_mem), 0);
    tick();
    chk("mis_req", 32'(dmem_req), 0);
    chk("mis_err", 32'(mem_error), 1);
    chk("mis_rw",  32'(RegWrite_wb), 0);
    chk("mis_m2r", 32'(MemtoReg_wb), 0);
    clr(); tick();
    chk("mis_err_end", 32'(mem_error), 0);

    // Read and write together
    alu_result_mem = 32'h300; MemRead_mem = 1; MemWrite_mem = 1; RegWrite_mem = 1;
    tick();
    chk("both_err", 32'(mem_error), 1);
    chk("both_req", 32'(dmem_req), 0);
    chk("both_rw",  32'(RegWrite_wb), 0);
    clr(); tick();

    // Timeout with no ack
    set_load(32'h400, 4);
    tick(); chk("to_w1_req", 32'(dmem_req), 1);
    tick(); chk("to_w2_req", 32'(dmem_req), 1);
    tick(); chk("to_w3_req", 32'(dmem_req), 1);
    chk("to_w3_stall", 32'(stall_mem), 1);
    tick(); chk("to_w4_req", 32'(dmem_req), 1);
    chk("to_w4_stall", 32'(stall_mem), 0);
    tick();
    chk("to_req",  32'(dmem_req), 0);
    chk("to_err",  32'(mem_error), 1);
    chk("to_rw",   32'(RegWrite_wb), 0);
    clr(); dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
    tick();
    dmem_ack = 0;
    chk("late_req", 32'(dmem_req), 0);
    chk("late_err", 32'(mem_error), 0);
    chk("late_rdata", read_data_wb, 0);

    // Ack in the timeout cycle completes normally
    set_load(32'h500, 3);
    tick(); tick(); tick(); tick();
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    #1 chk("edge_stall", 32'(stall_mem), 1);
    tick();
    dmem_ack = 0;
    chk("edge_err", 32'(mem_error), 0);
    chk("edge_req", 32'(dmem_req), 0);
    tick();
    chk("edge_rdata", read_data_wb, 32'hCAFEF00D);
    chk("edge_rw",    32'(RegWrite_wb), 1);
    chk("edge_rd",    32'(rd_wb), 3);
    clr(); tick();

    // Reset during the second WAIT cycle
    set_load(32'h600, 6);
    tick(); tick();
    chk("rw2_req", 32'(dmem_req), 1);
    reset = 1; clr();
    tick();
    chk("rw2_req_after",   32'(dmem_req), 0);
    chk("rw2_stall_after", 32'(stall_mem), 0);
    chk("rw2_addr", dmem_addr, 0);
    chk("rw2_alu",  alu_result_wb, 0);
    chk("rw2_rd",   32'(rd_wb), 0);
    reset = 0; dmem_ack = 1; dmem_rdata = 32'h77777777;
    tick();
    dmem_ack = 0;
    chk("rw2_late_req", 32'(dmem_req), 0);
    chk("rw2_late_err", 32'(mem_error), 0);
    tick();
    chk("rw2_late_rdata", read_data_wb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_access_unit

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, maximum WAIT cycles before the access is aborted (range 1..255).
REQ-002 SHALL use one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-003 SHALL have ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- alu_result_mem  in  32  ALU result / memory address from the EX/MEM register
- read_data2_mem  in  32  store data
- rd_mem  in  5  destination register
- MemRead_mem, MemtoReg_mem, MemWrite_mem, RegWrite_mem  in  1 each  control
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  access complete, one-cycle pulse
- stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- mem_error  out  1  one-cycle pulse on misaligned, illegal or timed-out access
- read_data_wb, alu_result_wb  out  32  MEM/WB data
- rd_wb  out  5  MEM/WB destination
- MemtoReg_wb, RegWrite_wb  out  1  MEM/WB control

Function
REQ-004 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-005 IDLE, with neither MemRead_mem nor MemWrite_mem set, SHALL load MEM/WB at the next edge (alu_result, rd, MemtoReg, RegWrite; read_data_wb = 0) and keep stall_mem low, giving a latency of 1 cycle.
REQ-006 IDLE, with exactly one of MemRead_mem or MemWrite_mem set and alu_result_mem[1:0] == 0, SHALL assert stall_mem combinationally in the same cycle, latch addr, wdata and we, and enter WAIT at the next edge.
REQ-007 A misaligned address (alu_result_mem[1:0] != 0) or MemRead_mem and MemWrite_mem both set SHALL issue no request, pulse mem_error, load a bubble into MEM/WB (RegWrite_wb = 0, MemtoReg_wb = 0) and keep the FSM in IDLE.
REQ-008 WAIT SHALL hold dmem_req = 1 with dmem_addr, dmem_we and dmem_wdata stable from the latched values; stall_mem SHALL stay high.
REQ-009 In WAIT, a high dmem_ack SHALL capture dmem_rdata for reads (0 for writes) and move the FSM to DONE at that edge; dmem_req SHALL be low in DONE.
REQ-010 DONE SHALL keep stall_mem low, load MEM/WB with the captured data and the EX/MEM control (for a store, RegWrite passes through as supplied), and move the FSM to IDLE at the next edge.
REQ-011 Every stalled edge (IDLE->WAIT and within WAIT) SHALL load a bubble into MEM/WB so that WB never repeats an instruction.
REQ-012 A WAIT cycle counter SHALL clear on entry to WAIT. If it reaches TIMEOUT_CYCLES with no ack, the block SHALL pulse mem_error, drop dmem_req, load a bubble and return to IDLE; stall_mem SHALL be low in that final cycle.
REQ-013 dmem_ack SHALL be ignored in IDLE and DONE; an ack arriving in the same cycle the timeout is reached SHALL win, giving normal completion with no error.
REQ-014 Full-load latency SHALL be 2 + N cycles, where N is the number of WAIT cycles up to and including the ack cycle; a zero-wait ack (in the first WAIT cycle) gives 3 cycles from IDLE to MEM/WB valid.

Reset
REQ-015 Reset SHALL force FSM = IDLE, counter = 0, and all MEM/WB outputs, dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_mem and mem_error to 0 at the next edge.
REQ-016 Reset asserted during WAIT SHALL drop dmem_req at that edge; any later ack SHALL be ignored.

Structure
REQ-017 Package mem_stage_pkg SHALL hold the FSM state enum (2-bit), the TIMEOUT_CYCLES default and the counter width (8 bits).
REQ-018 The MEM/WB output register SHALL be a sub-module named mem_wb_register with load, bubble and reset controls; FSM and datapath stay in mem_access_unit.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ALU op: alu_result 0x0000_0010, rd 5, RegWrite 1 -> next edge alu_result_wb 0x10, rd_wb 5, RegWrite_wb 1; stall_mem never high.
- Load: addr 0x100, ack after 3 WAIT cycles with rdata 0xDEAD_BEEF -> dmem_req high for 3 cycles, stall_mem high for 4 cycles, read_data_wb 0xDEADBEEF, MemtoReg_wb 1.
- Store: addr 0x200, wdata 0x1234_5678, zero-wait ack -> dmem_we 1 for one cycle, data stable; RegWrite_wb 0.
- Misaligned load at 0x102 -> no dmem_req, mem_error pulse for 1 cycle, bubble.
- No ack with TIMEOUT_CYCLES = 4 -> dmem_req high 4 cycles, mem_error pulse, IDLE; a late ack is ignored.
- Reset in the 2nd WAIT cycle -> dmem_req and stall_mem low next edge; all outputs 0.
